// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
//   Classifies a clean, debounced, clk-synchronous button level into
//   single-cycle event pulses (short, long, double, optional auto-repeat)
//   plus a "held" level. Downstream logic never has to time presses itself.
//
//   Optional feature macro: BTN_AUTO_REPEAT_EN
//     defined   -> repeat_pulse fires every RPT_TICKS ticks while in long hold
//     undefined -> repeat_pulse is tied 0, no repeat logic is built
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_level    in   debounced button level, 1 = pressed
//   short_pulse  out  one-cycle pulse: short press
//   long_pulse   out  one-cycle pulse: press reached LONG_TICKS
//   double_pulse out  one-cycle pulse: second short press inside double window
//   repeat_pulse out  one-cycle pulse: auto-repeat (0 without the macro)
//   held         out  high while in a pressed state
// -----------------------------------------------------------------------------
module btn_event_decoder #(
  parameter int TICK_DIV   = 100000,
  parameter int LONG_TICKS = 800,
  parameter int DBL_TICKS  = 250,
  parameter int RPT_TICKS  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAX_LD = (LONG_TICKS > DBL_TICKS) ? LONG_TICKS : DBL_TICKS;
  localparam int MAX_T  = (MAX_LD > RPT_TICKS) ? MAX_LD : RPT_TICKS;
  localparam int TW     = $clog2(TICK_DIV);
  localparam int CW     = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LONG_C    = CW'(LONG_TICKS);
  localparam logic [CW-1:0] DBL_C     = CW'(DBL_TICKS);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RPT_C     = CW'(RPT_TICKS);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_LONGH,
    S_WAIT,
    S_PRESS2
  } state_t;

  state_t          state, state_nx;
  logic            btn_prev;
  logic [TW-1:0]   tick_cnt;
  logic [CW-1:0]   cnt;
  logic            long_pend, long_pend_nx;
  logic            restart;
  logic            short_nx, long_nx, dbl_nx, rpt_nx;
  logic            rise, fall;

  assign rise = btn_level & ~btn_prev;
  assign fall = ~btn_level & btn_prev;

  always_comb begin
    state_nx     = state;
    short_nx     = 1'b0;
    long_nx      = 1'b0;
    dbl_nx       = 1'b0;
    rpt_nx       = 1'b0;
    long_pend_nx = 1'b0;
    restart      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) state_nx = S_PRESS;
      end
      S_PRESS: begin
        if (fall) begin
          if (DBL_TICKS == 0) begin
            state_nx = S_IDLE;
            short_nx = 1'b1;
          end else begin
            state_nx = S_WAIT;
          end
        end else if (cnt == LONG_C) begin
          state_nx = S_LONGH;
          long_nx  = 1'b1;
        end
      end
      S_LONGH: begin
        // long_pend holds the deferred long_pulse of the PRESS2 path; the
        // repeat period is measured from that pulse, so restart the counters.
        if (long_pend) begin
          long_nx = 1'b1;
          restart = 1'b1;
        end
        if (fall) begin
          state_nx = S_IDLE;
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (!long_pend && cnt == RPT_C) begin
          rpt_nx  = 1'b1;
          restart = 1'b1;
        end
`endif
      end
      S_WAIT: begin
        if (rise) begin
          state_nx = S_PRESS2;
        end else if (cnt == DBL_C) begin
          state_nx = S_IDLE;
          short_nx = 1'b1;
        end
      end
      S_PRESS2: begin
        if (fall) begin
          state_nx = S_IDLE;
          dbl_nx   = 1'b1;
        end else if (cnt == LONG_C) begin
          state_nx     = S_LONGH;
          short_nx     = 1'b1;
          long_pend_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      btn_prev     <= 1'b1;
      tick_cnt     <= '0;
      cnt          <= '0;
      long_pend    <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nx;
      btn_prev     <= btn_level;
      long_pend    <= long_pend_nx;
      short_pulse  <= short_nx;
      long_pulse   <= long_nx;
      double_pulse <= dbl_nx;
      held         <= (state_nx == S_PRESS) || (state_nx == S_LONGH) ||
                      (state_nx == S_PRESS2);
      if ((state_nx != state) || restart) begin
        tick_cnt <= '0;
        cnt      <= '0;
      end else if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        if (cnt != '1) cnt <= cnt + CW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_pulse <= 1'b0;
    else        repeat_pulse <= rpt_nx;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_event_decoder
//   Directed scenarios plus randomized press/release traffic for
//   btn_event_decoder (TICK_DIV=4, LONG_TICKS=10, DBL_TICKS=5, RPT_TICKS=3).
//   The reference model tracks the phase of a press and the number of clock
//   edges spent in it; a timeout of N ticks lands on edge N*TICK_DIV+1.
// -----------------------------------------------------------------------------
module tb_btn_event_decoder;

  localparam int TD   = 4;
  localparam int LT   = 10;
  localparam int DT   = 5;
  localparam int RT   = 3;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_level = 1'b0;
  logic short_pulse, long_pulse, double_pulse, repeat_pulse, held;

  btn_event_decoder #(
    .TICK_DIV(TD), .LONG_TICKS(LT), .DBL_TICKS(DT), .RPT_TICKS(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
    .short_pulse(short_pulse), .long_pulse(long_pulse),
    .double_pulse(double_pulse), .repeat_pulse(repeat_pulse), .held(held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // observed-event bookkeeping for directed scenarios
  int n_short, n_long, n_dbl, n_rpt, n_held;
  int last_short, last_long, last_dbl, first_rpt, last_rpt;

  // reference model
  localparam int P_IDLE = 0, P_PRESS = 1, P_LONGH = 2, P_WAIT = 3, P_PRESS2 = 4;
  int m_phase;
  int m_age;
  bit m_prev, m_pend;
  bit e_short, e_long, e_dbl, e_rpt, e_held;

  task automatic model_reset();
    m_phase = P_IDLE; m_age = 0; m_prev = 1'b1; m_pend = 1'b0;
    e_short = 0; e_long = 0; e_dbl = 0; e_rpt = 0; e_held = 0;
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_age   = 0;
  endtask

  task automatic model_edge(input bit lvl);
    bit rise, fall, pend_was;
    rise = lvl & ~m_prev;
    fall = ~lvl & m_prev;
    pend_was = m_pend;
    m_prev = lvl;
    e_short = 0; e_long = 0; e_dbl = 0; e_rpt = 0;
    m_age++;
    case (m_phase)
      P_IDLE:  if (rise) enter(P_PRESS);
      P_PRESS: begin
        if (fall) begin
          if (DT == 0) begin enter(P_IDLE); e_short = 1; end
          else enter(P_WAIT);
        end else if (m_age == LT * TD + 1) begin
          enter(P_LONGH); e_long = 1;
        end
      end
      P_LONGH: begin
        if (pend_was) begin e_long = 1; m_pend = 0; m_age = 0; end
        if (fall) enter(P_IDLE);
        else if (AUTO && !pend_was && m_age == RT * TD + 1) begin
          e_rpt = 1; m_age = 0;
        end
      end
      P_WAIT: begin
        if (rise) enter(P_PRESS2);
        else if (m_age == DT * TD + 1) begin enter(P_IDLE); e_short = 1; end
      end
      P_PRESS2: begin
        if (fall) begin enter(P_IDLE); e_dbl = 1; end
        else if (m_age == LT * TD + 1) begin
          enter(P_LONGH); e_short = 1; m_pend = 1;
        end
      end
      default: enter(P_IDLE);
    endcase
    e_held = (m_phase == P_PRESS) || (m_phase == P_LONGH) || (m_phase == P_PRESS2);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    check_bit("short_pulse",  short_pulse,  e_short);
    check_bit("long_pulse",   long_pulse,   e_long);
    check_bit("double_pulse", double_pulse, e_dbl);
    check_bit("repeat_pulse", repeat_pulse, e_rpt);
    check_bit("held",         held,         e_held);
  endtask

  task automatic clear_obs();
    n_short = 0; n_long = 0; n_dbl = 0; n_rpt = 0; n_held = 0;
    last_short = -1; last_long = -1; last_dbl = -1; first_rpt = -1; last_rpt = -1;
  endtask

  // one clock: drive at negedge, model the posedge, sample 1 time unit later
  task automatic step(input logic v);
    @(negedge clk);
    btn_level = v;
    @(posedge clk);
    cyc++;
    model_edge(v);
    #1;
    check_outputs();
    if (short_pulse)  begin n_short++; last_short = cyc; end
    if (long_pulse)   begin n_long++;  last_long  = cyc; end
    if (double_pulse) begin n_dbl++;   last_dbl   = cyc; end
    if (repeat_pulse) begin
      n_rpt++; last_rpt = cyc;
      if (first_rpt < 0) first_rpt = cyc;
    end
    if (held) n_held++;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin : stim
    int r, f, seg;
    logic lvl;
    model_reset();
    clear_obs();

    // reset state
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 5);

    // 1: short press
    clear_obs();
    hold(1, 20);
    f = cyc + 1;
    hold(0, 40);
    check_int("s1_short_count", n_short, 1);
    check_int("s1_short_delay", last_short - f, 21);
    check_int("s1_other_pulses", n_long + n_dbl + n_rpt, 0);

    // 2: long press
    clear_obs();
    r = cyc + 1;
    hold(1, 60);
    check_int("s2_long_delay", last_long - r, 41);
    check_int("s2_held_cycles", n_held, 60);
    check_int("s2_repeat_count", n_rpt, AUTO ? 1 : 0);
    hold(0, 30);
    check_int("s2_long_count", n_long, 1);
    check_int("s2_no_short_dbl", n_short + n_dbl, 0);

    // 3: double press
    clear_obs();
    hold(1, 8); hold(0, 8); hold(1, 8);
    f = cyc + 1;
    hold(0, 30);
    check_int("s3_dbl_count", n_dbl, 1);
    check_int("s3_dbl_delay", last_dbl - f, 0);
    check_int("s3_no_short", n_short, 0);

    // 4a: second press lands on the same edge as the window timeout
    clear_obs();
    hold(1, 8); hold(0, 21); hold(1, 8); hold(0, 30);
    check_int("s4_edge_wins_short", n_short, 0);
    check_int("s4_edge_wins_dbl", n_dbl, 1);

    // 4b: one edge later the window has already closed
    clear_obs();
    hold(1, 8); hold(0, 22); hold(1, 8); hold(0, 30);
    check_int("s4b_short_count", n_short, 2);
    check_int("s4b_dbl_count", n_dbl, 0);

    // PRESS2 held long: short then long, one cycle apart
    clear_obs();
    hold(1, 8); hold(0, 8);
    r = cyc + 1;
    hold(1, 50); hold(0, 30);
    check_int("p2l_short_delay", last_short - r, 41);
    check_int("p2l_long_delay", last_long - r, 42);
    check_int("p2l_counts", n_short * 10 + n_long * 100 + n_dbl, 110);

    // 5: async reset mid-press, button held through reset deassert
    clear_obs();
    hold(1, 15);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    hold(1, 50); hold(0, 30);
    check_int("s5_no_pulses", n_short + n_long + n_dbl + n_rpt, 0);
    check_int("s5_held_cycles", n_held, 0);

    // 6: long hold with auto-repeat
    clear_obs();
    r = cyc + 1;
    hold(1, 100); hold(0, 10);
    check_int("s6_long_delay", last_long - r, 41);
    check_int("s6_repeat_count", n_rpt, AUTO ? 4 : 0);
    if (AUTO) begin
      check_int("s6_first_repeat", first_rpt - r, 54);
      check_int("s6_last_repeat", last_rpt - r, 93);
    end

    // randomized traffic, durations biased toward the timing boundaries
    lvl = 1'b0;
    for (int k = 0; k < 250; k++) begin
      lvl = ~lvl;
      if ($urandom_range(0, 4) == 0)
        seg = (lvl ? 40 : 20) + int'($urandom_range(0, 2));
      else
        seg = int'($urandom_range(1, 50));
      hold(lvl, seg);
    end
    hold(0, 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
